// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: captures WIDTH-bit operands on start and adds
// them CHUNK bits per clock through one shared slice, rippling a carry register.
module chunk_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
        $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    int               shift;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] res;
    logic             carry_nx;

    // A new request is taken in IDLE and also in DONE, so results can stream back-to-back.
    assign accept = start && (state_q != S_RUN);

    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        shift = int'(cnt_q) * CHUNK;
        a_sh  = a_q >> shift;
        b_sh  = b_q >> shift;
        {carry_nx, res} = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                          + (CHUNK + 1)'(carry_q);

        case (state_q)
            S_RUN: begin
                sum_d   = (sum_q & ~(CMASK << shift)) | (WIDTH'(res) << shift);
                carry_d = carry_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    co_d    = carry_nx;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Subtraction is a + ~b + 1; the mux keeps an undriven ci out of sub results.
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : ci;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench: three chunk_serial_adder configurations (8/4, 32/32, 32/1)
// against an arithmetic reference model.
module tb_chunk_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       start_v, sub_v, ci_v;
    logic [2:0][31:0] a_v, b_v;
    logic [2:0]       busy_v, done_v, co_v, ovf_v;
    logic [2:0][31:0] sum_v;
    logic [7:0]       sum8;

    int tests = 0;
    int fails = 0;

    chunk_serial_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .ci(ci_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum8), .co(co_v[0]), .ovf(ovf_v[0])
    );
    assign sum_v[0] = {24'h0, sum8};

    chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) u_w32c32 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1]), .b(b_v[1]), .ci(ci_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .co(co_v[1]), .ovf(ovf_v[1])
    );

    chunk_serial_adder #(.WIDTH(32), .CHUNK(1)) u_w32c1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2]), .b(b_v[2]), .ci(ci_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .co(co_v[2]), .ovf(ovf_v[2])
    );

    function automatic int w_of(input int d);
        return (d == 0) ? 8 : 32;
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 32);
    endfunction

    // Reference: plain unsigned/signed arithmetic on W-bit values.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub,
                         output logic [31:0] s, output logic c, output logic o);
        longint mod, mask, ua, ub, sa, sb, ru, rs;
        mod  = longint'(1) << w;
        mask = mod - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - mod : ua;
        sb   = ub[w-1] ? ub - mod : ub;
        if (sub) begin
            ru = ua - ub;
            rs = sa - sb;
            c  = (ua >= ub);
        end else begin
            ru = ua + ub + longint'(ci);
            rs = sa + sb + longint'(ci);
            c  = (ru >= mod);
        end
        s = 32'(ru & mask);
        o = (rs > (mod / 2) - 1) || (rs < -(mod / 2));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation; inputs and stray start pulses are scrambled while busy.
    task automatic run_op(input string tag, input int d, input logic [31:0] a,
                          input logic [31:0] b, input logic ci, input logic sub);
        logic [31:0] es;
        logic        ec, eo;
        int          cyc;
        bit          seen;
        model(w_of(d), a, b, ci, sub, es, ec, eo);
        a_v[d] = a; b_v[d] = b; ci_v[d] = ci; sub_v[d] = sub; start_v[d] = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start_v[d] = 1'b0;
            if (done_v[d]) seen = 1;
            else if (busy_v[d]) begin
                a_v[d] = $urandom; b_v[d] = $urandom;
                ci_v[d] = 1'($urandom); sub_v[d] = 1'($urandom);
                start_v[d] = 1'($urandom);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(n_of(d) + 1));
        check({tag, " sum"}, sum_v[d], es);
        check({tag, " co"}, 32'(co_v[d]), 32'(ec));
        check({tag, " ovf"}, 32'(ovf_v[d]), 32'(eo));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done_v[d]), 32'd0);
        check({tag, " idle"}, 32'(busy_v[d]), 32'd0);
        check({tag, " sum_hold"}, sum_v[d], es);
    endtask

    initial begin
        int prev, ndone;
        logic [31:0] es;
        logic ec, eo;

        rst = 1'b1;
        start_v = '0; sub_v = '0; ci_v = '0; a_v = '0; b_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d busy", d), 32'(busy_v[d]), 32'd0);
            check($sformatf("reset%0d done", d), 32'(done_v[d]), 32'd0);
            check($sformatf("reset%0d sum", d), sum_v[d], 32'd0);
            check($sformatf("reset%0d co_ovf", d), {30'd0, co_v[d], ovf_v[d]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_3c_4b", 0, 32'h3C, 32'h4B, 1'b0, 1'b0);
        run_op("add_ff_01_ci", 0, 32'hFF, 32'h01, 1'b1, 1'b0);
        run_op("sub_05_07", 0, 32'h05, 32'h07, 1'b0, 1'b1);
        run_op("sub_80_01", 0, 32'h80, 32'h01, 1'b1, 1'b1);
        run_op("sub_00_80", 0, 32'h00, 32'h80, 1'b0, 1'b1);

        // Start held high: a result every NCHUNK+1 cycles.
        a_v[0] = 32'h3C; b_v[0] = 32'h4B; ci_v[0] = 1'b1; sub_v[0] = 1'b0; start_v[0] = 1'b1;
        model(8, 32'h3C, 32'h4B, 1'b1, 1'b0, es, ec, eo);
        prev = -1; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                ndone++;
                check("b2b sum", sum_v[0], es);
                if (prev >= 0) check("b2b spacing", 32'(i - prev), 32'd3);
                prev = i;
            end
        end
        check("b2b count", 32'(ndone), 32'd4);
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset after chunk 0 has been processed.
        a_v[0] = 32'h3C; b_v[0] = 32'h4B; ci_v[0] = 1'b0; sub_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        check("midrun busy_before", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun busy", 32'(busy_v[0]), 32'd0);
        check("midrun done", 32'(done_v[0]), 32'd0);
        check("midrun sum", sum_v[0], 32'd0);
        check("midrun co_ovf", {30'd0, co_v[0], ovf_v[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 0, 32'h05, 32'h07, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd8_%0d", i), 0, $urandom & 32'hFF, $urandom & 32'hFF,
                   1'($urandom), 1'($urandom));
            run_op($sformatf("rnd32c32_%0d", i), 1, $urandom, $urandom,
                   1'($urandom), 1'($urandom));
            run_op($sformatf("rnd32c1_%0d", i), 2, $urandom, $urandom,
                   1'($urandom), 1'($urandom));
        end
        run_op("edge32c1_max", 2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_op("edge32c32_min", 1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
